conditional_sum_adder_param: RTL and testbench

CONDITIONAL_SUM_ADDER_PARAM -- requirements
Module: conditional_sum_adder_param

---
 rtl/conditional_sum_adder_param.sv | 125 ++++++++++++
 tb/tb_conditional_sum_adder_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/conditional_sum_adder_param.sv
// Sequential conditional-sum adder/subtractor: one BLK-bit block resolved per cycle, LSB first.
// Optional feature: define CSA_SATURATE_EN to clamp the sum on two's-complement overflow.
module conditional_sum_adder_param #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned BLK   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             add_sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] ope1,
  input  logic [WIDTH-1:0] ope2,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overf,
  output logic             complete,
  output logic             busy
);

  localparam int unsigned NBLK = WIDTH / BLK;
  localparam int unsigned CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  if ((BLK < 2) || ((BLK & (BLK - 1)) != 0) || ((WIDTH % BLK) != 0)) begin : g_bad_cfg
    $error("conditional_sum_adder_param: WIDTH must be a multiple of BLK, BLK a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]             cnt;
  logic [WIDTH-1:0]          opa, opb, acc;
  logic                      carry;
  logic                      busy_nxt, complete_nxt;

  logic [NBLK-1:0][BLK-1:0]  a_blk, b_blk, acc_v;
  logic [BLK:0]              s0, s1, sel;
  logic [WIDTH-1:0]          acc_nxt, res;
  logic                      last, ov;

  assign a_blk = opa;
  assign b_blk = opb;

  // Conditional sums of the current block for both carry-ins, then carry select
  always_comb begin
    s0      = {1'b0, a_blk[cnt]} + {1'b0, b_blk[cnt]};
    s1      = s0 + (BLK+1)'(1);
    sel     = carry ? s1 : s0;
    acc_v   = acc;
    acc_v[cnt] = sel[BLK-1:0];
    acc_nxt = acc_v;
    last    = (cnt == CW'(NBLK - 1));
    // carry into the MSB recovered from its sum bit, xored with carry out
    ov      = opa[WIDTH-1] ^ opb[WIDTH-1] ^ acc_nxt[WIDTH-1] ^ sel[BLK];
    res     = acc_nxt;
`ifdef CSA_SATURATE_EN
    if (ov) begin
      res = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs, registered from the next state
  always_comb begin
    busy_nxt     = (state_nxt == CALC);
    complete_nxt = (state_nxt == DONE);
  end

  // Datapath: operand latch, block accumulation, final result capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overf    <= 1'b0;
      busy     <= 1'b0;
      complete <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      complete <= complete_nxt;
      if ((state != CALC) && start) begin
        opa   <= ope1;
        opb   <= add_sub ? ~ope2 : ope2;
        carry <= add_sub ? 1'b1 : Cin;
        cnt   <= '0;
      end else if (state == CALC) begin
        acc   <= acc_nxt;
        carry <= sel[BLK];
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum   <= res;
          cout  <= sel[BLK];
          overf <= ov;
        end
      end
    end
  end

endmodule

// File: tb/tb_conditional_sum_adder_param.sv
// Self-checking bench for conditional_sum_adder_param: a 64/8 and a 16/4 instance against an arithmetic model.
module tb_conditional_sum_adder_param;

  logic        clock = 1'b0;
  logic        reset, start_a, start_b, add_sub, Cin;
  logic [63:0] ope1, ope2;

  logic [63:0] sum_a;
  logic        cout_a, overf_a, complete_a, busy_a;
  logic [15:0] sum_b;
  logic        cout_b, overf_b, complete_b, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  conditional_sum_adder_param #(.WIDTH(64), .BLK(8)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .add_sub(add_sub), .Cin(Cin),
    .ope1(ope1), .ope2(ope2), .sum(sum_a), .cout(cout_a), .overf(overf_a),
    .complete(complete_a), .busy(busy_a)
  );

  conditional_sum_adder_param #(.WIDTH(16), .BLK(4)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .add_sub(add_sub), .Cin(Cin),
    .ope1(ope1[15:0]), .ope2(ope2[15:0]), .sum(sum_b), .cout(cout_b), .overf(overf_b),
    .complete(complete_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: plain w-bit two's-complement arithmetic
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                input logic cin, input int w, output logic [63:0] s,
                                output logic c, output logic ov);
    logic [64:0] full;
    logic [63:0] mask, beff;
    logic        ce;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    beff = (sub ? ~b : b) & mask;
    ce   = sub ? 1'b1 : cin;
    full = {1'b0, a & mask} + {1'b0, beff} + 65'(ce);
    c    = full[w];
    s    = full[63:0] & mask;
    ov   = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
`ifdef CSA_SATURATE_EN
    if (ov) s = a[w-1] ? (64'd1 << (w-1)) : (mask >> 1);
`endif
  endfunction

  task automatic get(input int which, output logic [63:0] s, output logic c, output logic o,
                     output logic cp, output logic bz);
    if (which == 0) begin
      s = sum_a; c = cout_a; o = overf_a; cp = complete_a; bz = busy_a;
    end else begin
      s = {48'd0, sum_b}; c = cout_b; o = overf_b; cp = complete_b; bz = busy_b;
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v;
    else            start_b = v;
  endtask

  // One operation: latency counted with the start-sampling edge as edge 1
  task automatic run_op(input string tag, input int which, input logic [63:0] a, input logic [63:0] b,
                        input logic sub, input logic cin, input bit mid_start);
    int          nblk, w, lat, pulses;
    logic [63:0] es, s;
    logic        ec, eo, c, o, cp, bz;
    bit          seen;
    nblk = (which == 0) ? 8 : 4;
    w    = (which == 0) ? 64 : 16;
    model(a, b, sub, cin, w, es, ec, eo);
    ope1 = a; ope2 = b; add_sub = sub; Cin = cin;
    set_start(which, 1'b1);
    step();
    lat = 1;
    set_start(which, 1'b0);
    ope1 = {$urandom, $urandom}; ope2 = {$urandom, $urandom};
    add_sub = 1'($urandom); Cin = 1'($urandom);
    seen = 1'b0;
    while (!seen && lat < 40) begin
      set_start(which, (mid_start && lat == 3) ? 1'b1 : 1'b0);
      step();
      lat++;
      get(which, s, c, o, cp, bz);
      if (cp) seen = 1'b1;
      else chk({tag, "_busy_calc"}, 64'(bz), 64'd1);
    end
    set_start(which, 1'b0);
    get(which, s, c, o, cp, bz);
    chk({tag, "_latency"}, 64'(lat), 64'(nblk + 1));
    chk({tag, "_sum"}, s, es);
    chk({tag, "_cout"}, 64'(c), 64'(ec));
    chk({tag, "_overf"}, 64'(o), 64'(eo));
    chk({tag, "_busy_done"}, 64'(bz), 64'd0);
    step();
    get(which, s, c, o, cp, bz);
    chk({tag, "_pulse_width"}, 64'(cp), 64'd0);
    chk({tag, "_sum_hold"}, s, es);
    if (mid_start) begin
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        get(which, s, c, o, cp, bz);
        if (cp) pulses++;
      end
      chk({tag, "_extra_pulses"}, 64'(pulses), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] es, s;
    logic        ec, eo, c, o, cp, bz;
    int          pulses, last_edge, edge_n, seen_n;
    logic [63:0] bb_a [3];
    logic [63:0] bb_b [3];

    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; add_sub = 1'b0; Cin = 1'b0;
    ope1 = '0; ope2 = '0;
    step(); step();
    chk("rst_sum_a", sum_a, 64'd0);
    chk("rst_flags_a", {60'd0, cout_a, overf_a, complete_a, busy_a}, 64'd0);
    chk("rst_sum_b", 64'(sum_b), 64'd0);
    chk("rst_flags_b", {60'd0, cout_b, overf_b, complete_b, busy_b}, 64'd0);
    reset = 1'b1;
    step();

    run_op("all_ones_plus_one", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    run_op("pos_overflow", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    run_op("neg_overflow", 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_5_7_midstart", 0, 64'd5, 64'd7, 1'b1, 1'b0, 1'b1);

    // Abort by reset in the 4th CALC cycle
    ope1 = 64'h1111_2222_3333_4444; ope2 = 64'h0F0F_0F0F_0F0F_0F0F; add_sub = 1'b0; Cin = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step(); step();
    chk("abort_busy_before", 64'(busy_a), 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_sum", sum_a, 64'd0);
    chk("abort_flags", {60'd0, cout_a, overf_a, complete_a, busy_a}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (complete_a) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    run_op("after_abort", 0, 64'h1111_2222_3333_4444, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1, 1'b0);

    // Back-to-back with start held high through DONE
    for (int k = 0; k < 3; k++) begin
      bb_a[k] = {$urandom, $urandom};
      bb_b[k] = {$urandom, $urandom};
    end
    add_sub = 1'b0; Cin = 1'b0;
    ope1 = bb_a[0]; ope2 = bb_b[0];
    start_a = 1'b1;
    step();
    edge_n = 1; last_edge = 0; seen_n = 0;
    while (seen_n < 3 && edge_n < 60) begin
      step();
      edge_n++;
      if (complete_a) begin
        model(bb_a[seen_n], bb_b[seen_n], 1'b0, 1'b0, 64, es, ec, eo);
        chk("b2b_sum", sum_a, es);
        chk("b2b_cout", 64'(cout_a), 64'(ec));
        chk("b2b_busy_done", 64'(busy_a), 64'd0);
        chk("b2b_spacing", 64'(edge_n - last_edge), (seen_n == 0) ? 64'd9 : 64'd9);
        last_edge = edge_n;
        seen_n++;
        if (seen_n < 3) begin
          ope1 = bb_a[seen_n]; ope2 = bb_b[seen_n];
        end else begin
          start_a = 1'b0;
        end
      end else begin
        chk("b2b_busy_calc", 64'(busy_a), 64'd1);
      end
    end
    start_a = 1'b0;
    chk("b2b_count", 64'(seen_n), 64'd3);
    step();
    chk("b2b_idle", {62'd0, complete_a, busy_a}, 64'd0);

    // Random operations on both widths
    for (int i = 0; i < 16; i++)
      run_op("rand64", 0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'b0);

    run_op("w16_1234_0fff", 1, 64'h1234, 64'h0FFF, 1'b0, 1'b1, 1'b0);
    run_op("w16_pos_ovf", 1, 64'h7FFF, 64'h0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_op("rand16", 1, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
             1'($urandom), 1'($urandom), 1'b0);

    get(0, s, c, o, cp, bz);
    chk("final_idle_a", {62'd0, cp, bz}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
